pe_seq_ctrl: RTL and testbench
==============================

// Module: pe_seq_ctrl
// PURPOSE
//  Sequencer for one MAC processing element (pe). Accepts a dot-product job, streams len x/weight pairs
//  from the x and weight buffers into the pe, then issues the bias uop and the flush uop.
//  Returns the pe result through a valid/ready port. Sits between the NPU job dispatcher and a single pe.
// PARAMETERS
//  XLEN     16  data width of x, weight, bias and result (matches `XLEN)
//  ADDR_W   10  buffer address width; address arithmetic wraps modulo 2**ADDR_W
//  LEN_W    10  width of job_len; 0..2**LEN_W-1 MACs per job
//  TIMEOUT  16  cycles allowed from flush to pe_out_valid_r before err_timeout
// PORTS
//  clk            in   1       clock
//  rst_n          in   1       asynchronous active-low reset
//  job_valid      in   1       job request
//  job_ready      out  1       job accepted when job_valid && job_ready
//  job_len        in   LEN_W   number of MAC uops
//  job_x_addr     in   ADDR_W  first x address
//  job_w_addr     in   ADDR_W  first weight address
//  job_b_addr     in   ADDR_W  bias address (weight buffer)
//  x_rd_en        out  1       x buffer read strobe
//  x_rd_addr      out  ADDR_W  x buffer address
//  x_rd_data      in   XLEN    x data, valid 1 cycle after x_rd_en
//  w_rd_en        out  1       weight buffer read strobe
//  w_rd_addr      out  ADDR_W  weight buffer address
//  w_rd_data      in   XLEN    weight data, valid 1 cycle after w_rd_en
//  pe_x           out  XLEN    to pe x
//  pe_weight      out  XLEN    to pe weight
//  pe_in_valid    out  1       to pe in_valid
//  pe_calc_bias   out  1       to pe calc_bias
//  pe_out_en      out  1       to pe out_en
//  pe_flush       out  1       to pe flush
//  pe_result_r    in   XLEN    from pe result_r
//  pe_out_valid_r in   1       from pe out_valid_r
//  pe_illegal_uop in   1       from pe illegal_uop
//  res_valid      out  1       result available
//  res_data       out  XLEN    result value
//  res_ready      in   1       result consumed when res_valid && res_ready
//  err_illegal    out  1       sticky: pe reported illegal_uop
//  err_timeout    out  1       sticky: no pe_out_valid_r within TIMEOUT
//  err_clr        in   1       clears both sticky errors
// BEHAVIOUR
//  Reset: state IDLE; every output 0, including registered pe_* controls, res_*, err_*, rd_en and addr.
//    Reset mid-job aborts the job with no flush issued.
//  States: IDLE -> MAC -> BIAS -> FLUSH -> WAIT -> IDLE.
//  IDLE: job_ready = !res_valid. On accept (cycle 0), latch len/addrs, counter i = 0.
//    Go to MAC, or straight to BIAS when job_len == 0.
//  MAC (cycles 1..len): x_rd_en = w_rd_en = 1, addrs = x_addr+i / w_addr+i with wrap.
//    Go to BIAS after i == len-1.
//  BIAS (1 cycle): w_rd_en = 1, w_rd_addr = b_addr, x_rd_en = 0. Go to FLUSH.
//  Issue stage is 1-cycle delayed. pe_in_valid (registered) is high the cycle after each read.
//    pe_x = x_rd_data and pe_weight = w_rd_data (combinational) while pe_in_valid.
//  Bias uop: pe_in_valid = pe_calc_bias = pe_out_en = 1, pe_x = 1, pe_weight = w_rd_data.
//    pe_x, pe_weight = 0 whenever pe_in_valid = 0.
//  FLUSH: pe_flush = 1 on the cycle after the bias uop, exactly 1 cycle. Then WAIT with timer = 0.
//  Job timing: in_valid cycles 2..len+1, bias cycle len+2, flush cycle len+3.
//  WAIT: on pe_out_valid_r, res_data <= pe_result_r and res_valid <= 1, then go to IDLE.
//    Timer reaching TIMEOUT sets err_timeout and returns to IDLE with no result.
//  Result port: res_valid and res_data hold until res_ready. The next job is blocked while res_valid.
//  pe_illegal_uop in any non-IDLE state: err_illegal <= 1, in-flight reads dropped,
//    pe_flush pulsed 1 cycle, return to IDLE, no result.
//  pe_illegal_uop in IDLE also sets err_illegal.
//  err_clr has priority against a same-cycle set on the flag it clears.
//  pe_out_valid_r outside WAIT is ignored.
// TESTING
//  1 len=32, x[i]=w[i]=1, bias=1: in_valid high for 32 cycles, then bias, flush at cycle 35; res_data from pe, res_valid=1.
//  2 len=0, bias=5: no x reads; bias uop at cycle 2 and flush at cycle 3; job_ready=0 until the result is consumed.
//  3 x_addr=2**ADDR_W-2, len=4: x_rd_addr sequence 1022,1023,0,1 (ADDR_W=10).
//  4 res_ready held 0 for 10 cycles: res_data stable and job_ready=0; after the handshake job_ready=1 next cycle.
//  5 pe_illegal_uop forced mid-MAC: err_illegal=1, one pe_flush pulse, IDLE, no res_valid; err_clr then clears the flag.
//  6 pe_out_valid_r withheld: err_timeout=1 exactly TIMEOUT cycles after flush; rst_n pulse mid-MAC zeroes all outputs.

Source files
------------

// File: rtl/pe_seq_ctrl_if.sv
// Bundles the job, buffer-read, pe and result signals of the pe sequencer.
// The master modport is the sequencer side; slave is the dispatcher/buffer/pe side.
interface pe_seq_ctrl_if #(
    parameter int XLEN   = 16,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
);
    logic              job_valid;
    logic              job_ready;
    logic [LEN_W-1:0]  job_len;
    logic [ADDR_W-1:0] job_x_addr;
    logic [ADDR_W-1:0] job_w_addr;
    logic [ADDR_W-1:0] job_b_addr;
    logic              x_rd_en;
    logic [ADDR_W-1:0] x_rd_addr;
    logic [XLEN-1:0]   x_rd_data;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [XLEN-1:0]   w_rd_data;
    logic [XLEN-1:0]   pe_x;
    logic [XLEN-1:0]   pe_weight;
    logic              pe_in_valid;
    logic              pe_calc_bias;
    logic              pe_out_en;
    logic              pe_flush;
    logic [XLEN-1:0]   pe_result_r;
    logic              pe_out_valid_r;
    logic              pe_illegal_uop;
    logic              res_valid;
    logic [XLEN-1:0]   res_data;
    logic              res_ready;

    modport master (
        input  job_valid, job_len, job_x_addr, job_w_addr, job_b_addr,
        input  x_rd_data, w_rd_data, pe_result_r, pe_out_valid_r, pe_illegal_uop, res_ready,
        output job_ready, x_rd_en, x_rd_addr, w_rd_en, w_rd_addr,
        output pe_x, pe_weight, pe_in_valid, pe_calc_bias, pe_out_en, pe_flush,
        output res_valid, res_data
    );

    modport slave (
        output job_valid, job_len, job_x_addr, job_w_addr, job_b_addr,
        output x_rd_data, w_rd_data, pe_result_r, pe_out_valid_r, pe_illegal_uop, res_ready,
        input  job_ready, x_rd_en, x_rd_addr, w_rd_en, w_rd_addr,
        input  pe_x, pe_weight, pe_in_valid, pe_calc_bias, pe_out_en, pe_flush,
        input  res_valid, res_data
    );
endinterface

// File: rtl/pe_seq_ctrl.sv
// Sequencer for one MAC pe: streams len x/weight pairs, then the bias and flush uops,
// and returns the pe result through a valid/ready port with sticky error flags.
module pe_seq_ctrl #(
    parameter int XLEN    = 16,
    parameter int ADDR_W  = 10,
    parameter int LEN_W   = 10,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    pe_seq_ctrl_if.master bus,
    output logic          err_illegal,
    output logic          err_timeout,
    input  logic          err_clr
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MAC   = 3'd1;
    localparam logic [2:0] S_BIAS  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [2:0]        state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt;
    logic [ADDR_W-1:0] x_base;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] b_addr_q;
    logic [TMR_W-1:0]  timer;
    logic              vld_p1;
    logic              bias_p1;
    logic              flush_p1;
    logic              res_valid_q;
    logic [XLEN-1:0]   res_data_q;
    logic              accept;
    logic              abort;
    logic              timeout_hit;

    assign accept      = (state == S_IDLE) && bus.job_valid && !res_valid_q;
    assign abort       = (state != S_IDLE) && bus.pe_illegal_uop;
    assign timeout_hit = (state == S_WAIT) && !bus.pe_out_valid_r
                         && (timer == TMR_W'(TIMEOUT - 1));

    assign bus.job_ready = (state == S_IDLE) && !res_valid_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;

    // Read stage: buffer strobes and addresses straight from the state
    always_comb begin
        bus.x_rd_en   = 1'b0;
        bus.x_rd_addr = '0;
        bus.w_rd_en   = 1'b0;
        bus.w_rd_addr = '0;
        if (state == S_MAC) begin
            bus.x_rd_en   = 1'b1;
            bus.x_rd_addr = x_base + ADDR_W'(cnt);
            bus.w_rd_en   = 1'b1;
            bus.w_rd_addr = w_base + ADDR_W'(cnt);
        end else if (state == S_BIAS) begin
            bus.w_rd_en   = 1'b1;
            bus.w_rd_addr = b_addr_q;
        end
    end

    // Issue stage: one cycle behind the read, buffer data passed through while valid
    assign bus.pe_in_valid  = vld_p1;
    assign bus.pe_calc_bias = bias_p1;
    assign bus.pe_out_en    = bias_p1;
    assign bus.pe_flush     = flush_p1;
    assign bus.pe_x         = vld_p1 ? (bias_p1 ? XLEN'(1) : bus.x_rd_data) : '0;
    assign bus.pe_weight    = vld_p1 ? bus.w_rd_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            len_q       <= '0;
            cnt         <= '0;
            x_base      <= '0;
            w_base      <= '0;
            b_addr_q    <= '0;
            timer       <= '0;
            vld_p1      <= 1'b0;
            bias_p1     <= 1'b0;
            flush_p1    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            vld_p1   <= 1'b0;
            bias_p1  <= 1'b0;
            flush_p1 <= 1'b0;
            if (res_valid_q && bus.res_ready)
                res_valid_q <= 1'b0;
            if (abort) begin
                // drop whatever is in flight and still clear the pe accumulator
                state    <= S_IDLE;
                flush_p1 <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: if (accept) begin
                        len_q    <= bus.job_len;
                        x_base   <= bus.job_x_addr;
                        w_base   <= bus.job_w_addr;
                        b_addr_q <= bus.job_b_addr;
                        cnt      <= '0;
                        state    <= (bus.job_len == '0) ? S_BIAS : S_MAC;
                    end
                    S_MAC: begin
                        vld_p1 <= 1'b1;
                        if (cnt == len_q - LEN_W'(1))
                            state <= S_BIAS;
                        else
                            cnt <= cnt + LEN_W'(1);
                    end
                    S_BIAS: begin
                        vld_p1  <= 1'b1;
                        bias_p1 <= 1'b1;
                        state   <= S_FLUSH;
                    end
                    S_FLUSH: begin
                        flush_p1 <= 1'b1;
                        timer    <= '0;
                        state    <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (bus.pe_out_valid_r) begin
                            res_data_q  <= bus.pe_result_r;
                            res_valid_q <= 1'b1;
                            state       <= S_IDLE;
                        end else if (timeout_hit) begin
                            state <= S_IDLE;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Sticky errors; a clear wins over a same-cycle set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (err_clr)
                err_illegal <= 1'b0;
            else if (bus.pe_illegal_uop)
                err_illegal <= 1'b1;
            if (err_clr)
                err_timeout <= 1'b0;
            else if (timeout_hit && !abort)
                err_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl with buffer memories and a small accumulate/flush pe model.
module tb_pe_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_illegal, err_timeout;
    logic err_clr = 1'b0;

    pe_seq_ctrl_if #(.XLEN(16), .ADDR_W(10), .LEN_W(10)) bus ();

    pe_seq_ctrl #(.XLEN(16), .ADDR_W(10), .LEN_W(10), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .err_illegal (err_illegal),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    logic [15:0] xmem [1024];
    logic [15:0] wmem [1024];
    logic [15:0] acc;
    int          dly;
    logic        pe_mute = 1'b0;

    always @(posedge clk) begin
        if (bus.x_rd_en) bus.x_rd_data <= xmem[bus.x_rd_addr];
        if (bus.w_rd_en) bus.w_rd_data <= wmem[bus.w_rd_addr];
    end

    // pe model: accumulate on in_valid, answer two cycles after a flush
    always @(posedge clk) begin
        bus.pe_out_valid_r <= 1'b0;
        if (!rst_n) begin
            acc <= '0;
            dly <= 0;
        end else begin
            if (bus.pe_in_valid) acc <= acc + 16'(bus.pe_x * bus.pe_weight);
            if (bus.pe_flush) dly <= 2;
            else if (dly == 1) begin
                if (!pe_mute) begin
                    bus.pe_out_valid_r <= 1'b1;
                    bus.pe_result_r    <= acc;
                end
                acc <= '0;
                dly <= 0;
            end else if (dly != 0) dly <= dly - 1;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int first_iv, last_iv, n_iv, bias_cyc, flush_cyc, flush_cnt, to_cyc, res_cyc;
    logic [15:0] bias_x, bias_w;
    logic rdy_seen;
    logic snap_flush, snap_iv, snap_err, snap_rdy, snap_xen;
    logic [9:0] xaddr_q [$];

    task automatic run_job(input int len, input int xa, input int wa, input int ba,
                           input int inj, input int ncyc);
        int guard = 0;
        while (!bus.job_ready && guard < 50) begin
            step();
            guard++;
        end
        if (!bus.job_ready) check("job_ready_wait", 0, 1);
        bus.job_valid  = 1'b1;
        bus.job_len    = 10'(len);
        bus.job_x_addr = 10'(xa);
        bus.job_w_addr = 10'(wa);
        bus.job_b_addr = 10'(ba);
        step();
        bus.job_valid = 1'b0;
        first_iv = -1; last_iv = -1; n_iv = 0; bias_cyc = -1; flush_cyc = -1;
        flush_cnt = 0; to_cyc = -1; res_cyc = -1; rdy_seen = 1'b0;
        bias_x = '0; bias_w = '0;
        xaddr_q.delete();
        for (int c = 1; c <= ncyc; c++) begin
            if (bus.pe_in_valid && !bus.pe_calc_bias) begin
                if (first_iv < 0) first_iv = c;
                last_iv = c;
                n_iv++;
            end
            if (bus.pe_calc_bias) begin
                bias_cyc = c;
                bias_x   = bus.pe_x;
                bias_w   = bus.pe_weight;
            end
            if (bus.pe_flush) begin
                flush_cnt++;
                flush_cyc = c;
            end
            if (bus.x_rd_en) xaddr_q.push_back(bus.x_rd_addr);
            if (bus.job_ready) rdy_seen = 1'b1;
            if (err_timeout && to_cyc < 0) to_cyc = c;
            if (c == inj + 1) begin
                snap_flush = bus.pe_flush;
                snap_iv    = bus.pe_in_valid;
                snap_err   = err_illegal;
                snap_rdy   = bus.job_ready;
                snap_xen   = bus.x_rd_en;
            end
            if (bus.res_valid) begin
                res_cyc = c;
                break;
            end
            bus.pe_illegal_uop = (c == inj);
            step();
        end
        bus.pe_illegal_uop = 1'b0;
    endtask

    task automatic consume();
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
    endtask

    logic [15:0] held;
    logic        stable;
    int          flushes;

    initial begin
        bus.job_valid = 1'b0; bus.job_len = '0; bus.job_x_addr = '0;
        bus.job_w_addr = '0; bus.job_b_addr = '0; bus.res_ready = 1'b0;
        bus.pe_illegal_uop = 1'b0; bus.pe_result_r = '0;
        for (int i = 0; i < 1024; i++) begin
            xmem[i] = '0;
            wmem[i] = '0;
        end
        for (int i = 0; i < 32; i++) begin
            xmem[10 + i]  = 16'd1;
            wmem[300 + i] = 16'd1;
        end
        wmem[600] = 16'd1;
        wmem[601] = 16'd5;
        wmem[602] = 16'd7;
        xmem[1022] = 16'd2; xmem[1023] = 16'd3; xmem[0] = 16'd4; xmem[1] = 16'd5;
        for (int i = 0; i < 4; i++) wmem[400 + i] = 16'd1;

        repeat (3) step();
        check("rst_x_rd_en", bus.x_rd_en, 0);
        check("rst_w_rd_en", bus.w_rd_en, 0);
        check("rst_x_rd_addr", bus.x_rd_addr, 0);
        check("rst_pe_in_valid", bus.pe_in_valid, 0);
        check("rst_pe_flush", bus.pe_flush, 0);
        check("rst_pe_out_en", bus.pe_out_en, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_err_illegal", err_illegal, 0);
        check("rst_err_timeout", err_timeout, 0);
        rst_n = 1'b1;
        step();
        check("idle_job_ready", bus.job_ready, 1);

        // len=32 with unit data, then hold the result
        run_job(32, 10, 300, 600, -1, 80);
        check("t1_first_iv", first_iv, 2);
        check("t1_last_iv", last_iv, 33);
        check("t1_n_iv", n_iv, 32);
        check("t1_x_reads", xaddr_q.size(), 32);
        check("t1_bias_cyc", bias_cyc, 34);
        check("t1_bias_x", bias_x, 1);
        check("t1_bias_w", bias_w, 1);
        check("t1_flush_cyc", flush_cyc, 35);
        check("t1_flush_cnt", flush_cnt, 1);
        check("t1_ready_busy", rdy_seen, 0);
        check("t1_res_valid", bus.res_valid, 1);
        check("t1_res_data", bus.res_data, 33);

        held = bus.res_data;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.res_data !== held || bus.res_valid !== 1'b1 || bus.job_ready !== 1'b0)
                stable = 1'b0;
        end
        check("t4_hold_stable", stable, 1);
        consume();
        check("t4_res_valid_clr", bus.res_valid, 0);
        check("t4_ready_after", bus.job_ready, 1);

        // len=0: bias straight away
        run_job(0, 10, 300, 601, -1, 40);
        check("t2_x_reads", xaddr_q.size(), 0);
        check("t2_no_mac_iv", n_iv, 0);
        check("t2_bias_cyc", bias_cyc, 2);
        check("t2_bias_w", bias_w, 5);
        check("t2_flush_cyc", flush_cyc, 3);
        check("t2_ready_busy", rdy_seen, 0);
        check("t2_res_data", bus.res_data, 5);
        check("t2_ready_blocked", bus.job_ready, 0);
        consume();

        // x address wrap
        run_job(4, 1022, 400, 602, -1, 40);
        check("t3_x_reads", xaddr_q.size(), 4);
        if (xaddr_q.size() == 4) begin
            check("t3_addr0", xaddr_q[0], 1022);
            check("t3_addr1", xaddr_q[1], 1023);
            check("t3_addr2", xaddr_q[2], 0);
            check("t3_addr3", xaddr_q[3], 1);
        end
        check("t3_res_data", bus.res_data, 21);
        consume();

        // illegal uop mid-MAC
        run_job(8, 10, 300, 600, 4, 20);
        check("t5_flush_after", snap_flush, 1);
        check("t5_iv_dropped", snap_iv, 0);
        check("t5_err_set", snap_err, 1);
        check("t5_idle", snap_rdy, 1);
        check("t5_no_read", snap_xen, 0);
        check("t5_flush_cnt", flush_cnt, 1);
        check("t5_no_result", res_cyc, -1);
        check("t5_res_valid", bus.res_valid, 0);
        err_clr = 1'b1;
        bus.pe_illegal_uop = 1'b1;
        step();
        check("t5_clr_priority", err_illegal, 0);
        err_clr = 1'b0;
        step();
        check("t5_idle_set", err_illegal, 1);
        check("t5_idle_no_flush", bus.pe_flush, 0);
        bus.pe_illegal_uop = 1'b0;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("t5_clr", err_illegal, 0);

        // timeout with the pe silent
        pe_mute = 1'b1;
        run_job(2, 10, 300, 600, -1, 30);
        check("t6_flush_cyc", flush_cyc, 5);
        check("t6_timeout_cyc", to_cyc, 21);
        check("t6_no_result", res_cyc, -1);
        check("t6_idle", bus.job_ready, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("t6_clr", err_timeout, 0);
        pe_mute = 1'b0;

        // asynchronous reset in the middle of MAC
        run_job(20, 10, 300, 600, -1, 5);
        check("t6_in_mac", bus.x_rd_en, 1);
        rst_n = 1'b0;
        #1;
        check("arst_x_rd_en", bus.x_rd_en, 0);
        check("arst_x_rd_addr", bus.x_rd_addr, 0);
        check("arst_pe_in_valid", bus.pe_in_valid, 0);
        check("arst_pe_x", bus.pe_x, 0);
        check("arst_pe_flush", bus.pe_flush, 0);
        check("arst_res_valid", bus.res_valid, 0);
        #2;
        rst_n = 1'b1;
        flushes = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.pe_flush) flushes++;
        end
        check("arst_no_flush", flushes, 0);
        check("arst_idle", bus.job_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
